// File: rtl/adk_tb_ctl_n_if.sv
// Bus bundle between the ADK sequencer side and the TB control block:
// W-control/W-bus inputs, TB status inputs and the strobe/readback outputs.
interface adk_tb_ctl_n_if #(
    parameter int WAYS    = 2,
    parameter int TB_SETS = 64
);
    localparam int IDX_W = $clog2(TB_SETS);

    logic             d_clk_en_h;
    logic [5:0]       wctrl_h;
    logic [3:0]       wbus_h;
    logic             phase_1_h;
    logic [WAYS-1:0]  tb_hit_h;
    logic             inval_check_h;
    logic             write_vect_occ_l;
    logic             bus_grant_dec_h;
    logic             sweep_stall_h;

    logic [WAYS-1:0]  tb_grp_wr_h;
    logic             tb_inval_all_h;
    logic [IDX_W-1:0] tb_index_h;
    logic             sweep_busy_h;
    logic             sweep_done_h;
    logic             mme_h;
    logic             wr_vect_h;
    logic [3:0]       tb_ctl_h;
    logic [3:0]       wbus_out_h;

    modport master (
        output d_clk_en_h, wctrl_h, wbus_h, phase_1_h, tb_hit_h, inval_check_h,
               write_vect_occ_l, bus_grant_dec_h, sweep_stall_h,
        input  tb_grp_wr_h, tb_inval_all_h, tb_index_h, sweep_busy_h, sweep_done_h,
               mme_h, wr_vect_h, tb_ctl_h, wbus_out_h
    );

    modport slave (
        input  d_clk_en_h, wctrl_h, wbus_h, phase_1_h, tb_hit_h, inval_check_h,
               write_vect_occ_l, bus_grant_dec_h, sweep_stall_h,
        output tb_grp_wr_h, tb_inval_all_h, tb_index_h, sweep_busy_h, sweep_done_h,
               mme_h, wr_vect_h, tb_ctl_h, wbus_out_h
    );
endinterface

// File: rtl/adk_tb_ctl_n.sv
// ADK translation-buffer control: memory status/control registers, round-robin or
// forced-way TB write strobes, and a hardware invalidate-all sweep.
module adk_tb_ctl_n #(
    parameter int         WAYS                 = 2,
    parameter int         TB_SETS              = 64,
    parameter logic [5:0] UC_WCTRL_MEMSCAR_WB  = 6'h21,
    parameter logic [5:0] UC_WCTRL_MEMSCR_WB   = 6'h22,
    parameter logic [5:0] UC_WCTRL_MEMSCR      = 6'h23,
    parameter logic [5:0] UC_WCTRL_TB_WB       = 6'h24,
    parameter logic [5:0] UC_WCTRL_CLRTB_VA_WB = 6'h25
) (
    input logic          b_clk_l,
    input logic          proc_init_l,
    adk_tb_ctl_n_if.slave bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(TB_SETS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TB_SETS - 1);

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] index_q;
    logic             done_q;
    logic [3:0]       scar_q;
    logic [3:0]       tb_ctl_q;
    logic             mme_q;
    logic             wvor_q;
    logic [WAY_W-1:0] repl_ptr_q;
    logic [WAYS-1:0]  latched_hit_q;

    logic             scar_wr_d;
    logic             scr_wr_d;
    logic             tb_wb_d;
    logic             rd_en_d;
    logic             start_d;
    logic             hit_any_d;
    logic [WAY_W-1:0] victim_d;
    logic [WAYS-1:0]  victim_oh_d;
    logic [WAYS-1:0]  grp_wr_d;
    logic [3:0]       rd_data_d;

    assign scar_wr_d = bus.d_clk_en_h && (bus.wctrl_h == UC_WCTRL_MEMSCAR_WB);
    assign scr_wr_d  = bus.d_clk_en_h && (bus.wctrl_h == UC_WCTRL_MEMSCR_WB);
    assign tb_wb_d   = bus.d_clk_en_h && (bus.wctrl_h == UC_WCTRL_TB_WB) && (state_q == IDLE);
    assign rd_en_d   = (bus.wctrl_h == UC_WCTRL_MEMSCR) && !bus.phase_1_h && !scar_q[3];
    assign start_d   = scr_wr_d && (scar_q == 4'd4) && bus.wbus_h[0] && (state_q == IDLE);
    assign hit_any_d = |latched_hit_q;

    // Forced way wins over the round-robin pointer; upper TB_CTL bits fold away.
    assign victim_d = tb_ctl_q[3] ? tb_ctl_q[WAY_W-1:0] : repl_ptr_q;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_victim_oh
        assign victim_oh_d[gi] = (victim_d == WAY_W'(gi));
    end

    always_comb begin
        grp_wr_d = '0;
        if (state_q == SWEEP) begin
            grp_wr_d = '1;
        end else if ((bus.wctrl_h == UC_WCTRL_CLRTB_VA_WB) && !bus.inval_check_h) begin
            grp_wr_d = '1;
        end else if (tb_wb_d) begin
            grp_wr_d = hit_any_d ? latched_hit_q : victim_oh_d;
        end
    end

    always_comb begin
        rd_data_d = 4'b1111;
        if (rd_en_d) begin
            case (scar_q[2:0])
                3'd0:    rd_data_d = {3'b000, mme_q};
                3'd2:    rd_data_d = {3'b000, wvor_q};
                3'd3:    rd_data_d = tb_ctl_q;
                3'd4:    rd_data_d = {3'b000, state_q == SWEEP};
                3'd5:    rd_data_d = 4'(repl_ptr_q);
                default: rd_data_d = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge b_clk_l) begin
        if (!proc_init_l) begin
            scar_q        <= '0;
            mme_q         <= 1'b0;
            wvor_q        <= 1'b0;
            tb_ctl_q      <= '0;
            repl_ptr_q    <= '0;
            latched_hit_q <= '0;
        end else begin
            if (scar_wr_d) scar_q <= bus.wbus_h;
            if (scr_wr_d && scar_q == 4'd0) mme_q <= bus.wbus_h[0];
            if (scr_wr_d && scar_q == 4'd3) tb_ctl_q <= bus.wbus_h;
            // A pending write-vector event outranks both clear and software write.
            if (!bus.write_vect_occ_l) begin
                wvor_q <= 1'b1;
            end else if (bus.bus_grant_dec_h && bus.phase_1_h) begin
                wvor_q <= 1'b0;
            end else if (scr_wr_d && scar_q == 4'd2) begin
                wvor_q <= bus.wbus_h[0];
            end
            if (tb_wb_d && !hit_any_d && !tb_ctl_q[3]) repl_ptr_q <= repl_ptr_q + WAY_W'(1);
            if (bus.phase_1_h) latched_hit_q <= bus.tb_hit_h;
        end
    end

    always_ff @(posedge b_clk_l) begin
        if (!proc_init_l) begin
            state_q <= IDLE;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q <= SWEEP;
                        index_q <= '0;
                    end
                end
                SWEEP: begin
                    if (!bus.sweep_stall_h) begin
                        index_q <= index_q + IDX_W'(1);
                        if (index_q == LAST_IDX) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tb_grp_wr_h    = grp_wr_d;
    assign bus.tb_inval_all_h = (state_q == SWEEP);
    assign bus.sweep_busy_h   = (state_q == SWEEP);
    assign bus.tb_index_h     = index_q;
    assign bus.sweep_done_h   = done_q;
    assign bus.mme_h          = mme_q;
    assign bus.wr_vect_h      = wvor_q;
    assign bus.tb_ctl_h       = tb_ctl_q;
    assign bus.wbus_out_h     = rd_data_d;
endmodule

// File: tb/tb_adk_tb_ctl_n.sv
// Self-checking bench for adk_tb_ctl_n (4 ways, 8 sets): directed scenarios plus
// randomized traffic against a behavioural register/sweep model.
module tb_adk_tb_ctl_n;
    localparam int WAYS = 4;
    localparam int SETS = 8;
    localparam int IW   = $clog2(SETS);
    localparam logic [5:0] C_IDLE    = 6'h00;
    localparam logic [5:0] C_SCAR_WB = 6'h21;
    localparam logic [5:0] C_SCR_WB  = 6'h22;
    localparam logic [5:0] C_SCR_RD  = 6'h23;
    localparam logic [5:0] C_TB_WB   = 6'h24;
    localparam logic [5:0] C_CLRTB   = 6'h25;
    localparam logic [WAYS-1:0] ALL  = '1;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    int checks = 0;
    int errors = 0;

    // Architectural model state
    int m_scar, m_mme, m_wvor, m_tbctl, m_ptr, m_hit, m_busy, m_idx, m_done;

    adk_tb_ctl_n_if #(.WAYS(WAYS), .TB_SETS(SETS)) ifc ();

    adk_tb_ctl_n #(
        .WAYS(WAYS), .TB_SETS(SETS),
        .UC_WCTRL_MEMSCAR_WB(C_SCAR_WB), .UC_WCTRL_MEMSCR_WB(C_SCR_WB),
        .UC_WCTRL_MEMSCR(C_SCR_RD), .UC_WCTRL_TB_WB(C_TB_WB),
        .UC_WCTRL_CLRTB_VA_WB(C_CLRTB)
    ) dut (
        .b_clk_l    (clk),
        .proc_init_l(rst_l),
        .bus        (ifc)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        ifc.d_clk_en_h       = 1'b1;
        ifc.wctrl_h          = C_IDLE;
        ifc.wbus_h           = 4'h0;
        ifc.phase_1_h        = 1'b0;
        ifc.tb_hit_h         = '0;
        ifc.inval_check_h    = 1'b0;
        ifc.write_vect_occ_l = 1'b1;
        ifc.bus_grant_dec_h  = 1'b0;
        ifc.sweep_stall_h    = 1'b0;
    endtask

    function automatic logic [WAYS-1:0] exp_grp();
        int way;
        if (m_busy != 0) return ALL;
        if (ifc.wctrl_h == C_CLRTB && !ifc.inval_check_h) return ALL;
        if (ifc.wctrl_h == C_TB_WB && ifc.d_clk_en_h) begin
            if (m_hit != 0) return WAYS'(m_hit);
            way = (m_tbctl >= 8) ? (m_tbctl % WAYS) : m_ptr;
            return WAYS'(1 << way);
        end
        return '0;
    endfunction

    function automatic logic [3:0] exp_rd();
        if (ifc.wctrl_h != C_SCR_RD || ifc.phase_1_h || m_scar >= 8) return 4'hF;
        case (m_scar)
            0:       return 4'(m_mme);
            2:       return 4'(m_wvor);
            3:       return 4'(m_tbctl);
            4:       return 4'(m_busy);
            5:       return 4'(m_ptr);
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [10:0] exp_regs();
        return {m_mme[0], m_wvor[0], 4'(m_tbctl), m_busy[0], m_done[0], IW'(m_idx)};
    endfunction

    function automatic logic [10:0] dut_regs();
        return {ifc.mme_h, ifc.wr_vect_h, ifc.tb_ctl_h, ifc.sweep_busy_h,
                ifc.sweep_done_h, ifc.tb_index_h};
    endfunction

    // Advance one clock: compute the model's next state from the inputs now applied.
    task automatic tick();
        int n_scar, n_mme, n_wvor, n_tbctl, n_ptr, n_hit, n_busy, n_idx, n_done;
        bit scar_w, scr_w;
        n_scar = m_scar; n_mme = m_mme; n_wvor = m_wvor; n_tbctl = m_tbctl;
        n_ptr = m_ptr; n_hit = m_hit; n_busy = m_busy; n_idx = m_idx; n_done = 0;
        scar_w = ifc.d_clk_en_h && ifc.wctrl_h == C_SCAR_WB;
        scr_w  = ifc.d_clk_en_h && ifc.wctrl_h == C_SCR_WB;
        if (scar_w) n_scar = int'(ifc.wbus_h);
        if (scr_w && m_scar == 0) n_mme = int'(ifc.wbus_h[0]);
        if (scr_w && m_scar == 3) n_tbctl = int'(ifc.wbus_h);
        if (!ifc.write_vect_occ_l) n_wvor = 1;
        else if (ifc.bus_grant_dec_h && ifc.phase_1_h) n_wvor = 0;
        else if (scr_w && m_scar == 2) n_wvor = int'(ifc.wbus_h[0]);
        if (m_busy == 0 && ifc.d_clk_en_h && ifc.wctrl_h == C_TB_WB && m_hit == 0 && m_tbctl < 8)
            n_ptr = (m_ptr + 1) % WAYS;
        if (ifc.phase_1_h) n_hit = int'(ifc.tb_hit_h);
        if (m_busy != 0) begin
            if (!ifc.sweep_stall_h) begin
                if (m_idx == SETS - 1) begin
                    n_busy = 0; n_done = 1; n_idx = 0;
                end else begin
                    n_idx = m_idx + 1;
                end
            end
        end else if (scr_w && m_scar == 4 && ifc.wbus_h[0]) begin
            n_busy = 1; n_idx = 0;
        end
        if (!rst_l) begin
            n_scar = 0; n_mme = 0; n_wvor = 0; n_tbctl = 0; n_ptr = 0;
            n_hit = 0; n_busy = 0; n_idx = 0; n_done = 0;
        end
        @(posedge clk);
        m_scar = n_scar; m_mme = n_mme; m_wvor = n_wvor; m_tbctl = n_tbctl; m_ptr = n_ptr;
        m_hit = n_hit; m_busy = n_busy; m_idx = n_idx; m_done = n_done;
        @(negedge clk);
    endtask

    task automatic wr_reg(input int sel, input int val);
        idle_inputs();
        ifc.wctrl_h = C_SCAR_WB; ifc.wbus_h = 4'(sel);
        tick();
        ifc.wctrl_h = C_SCR_WB; ifc.wbus_h = 4'(val);
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_l = 1'b0;
        ifc.wbus_h = 4'hF;
        tick();
        tick();
        idle_inputs();
        #1;
        checks++;
        if (dut_regs() !== 11'h0 || dut_regs() !== exp_regs()) begin
            errors++; $display("FAIL reset_regs got %h exp %h", dut_regs(), 11'h0);
        end
        checks++;
        if ({ifc.tb_grp_wr_h, ifc.tb_inval_all_h, ifc.wbus_out_h} !== {ALL ^ ALL, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL reset_comb got grp=%h inval=%b rd=%h exp grp=0 inval=0 rd=f",
                     ifc.tb_grp_wr_h, ifc.tb_inval_all_h, ifc.wbus_out_h);
        end
        $display("txn reset regs=%h rd=%h", dut_regs(), ifc.wbus_out_h);
        rst_l = 1'b1;
        tick();
    endtask

    task automatic test_mme();
        wr_reg(0, 1);
        #1;
        checks++;
        if (ifc.mme_h !== 1'b1 || m_mme != 1) begin
            errors++; $display("FAIL mme_write got %b exp 1", ifc.mme_h);
        end
        ifc.wctrl_h = C_SCR_RD;
        #1;
        checks++;
        if (ifc.wbus_out_h !== 4'b0001 || exp_rd() !== 4'b0001) begin
            errors++; $display("FAIL mme_read got %h exp 1", ifc.wbus_out_h);
        end
        $display("txn mme read rd=%h", ifc.wbus_out_h);
        ifc.wctrl_h = C_IDLE;
        #1;
        checks++;
        if (ifc.wbus_out_h !== 4'b1111) begin
            errors++; $display("FAIL idle_read got %h exp f", ifc.wbus_out_h);
        end
        tick();
    endtask

    task automatic test_round_robin();
        wr_reg(3, 0);
        ifc.phase_1_h = 1'b1; ifc.tb_hit_h = '0;
        tick();
        for (int i = 0; i < WAYS; i++) begin
            idle_inputs();
            ifc.wctrl_h = C_TB_WB;
            #1;
            checks++;
            if (ifc.tb_grp_wr_h !== WAYS'(1 << i) || exp_grp() !== WAYS'(1 << i)) begin
                errors++; $display("FAIL rr_strobe%0d got %h exp %h", i, ifc.tb_grp_wr_h, WAYS'(1 << i));
            end
            $display("txn rr miss %0d grp=%h", i, ifc.tb_grp_wr_h);
            tick();
        end
        idle_inputs();
        ifc.wctrl_h = C_SCAR_WB; ifc.wbus_h = 4'd5;
        tick();
        idle_inputs();
        ifc.wctrl_h = C_SCR_RD;
        #1;
        checks++;
        if (ifc.wbus_out_h !== 4'b0000 || exp_rd() !== 4'b0000) begin
            errors++; $display("FAIL rr_ptr_wrap got %h exp 0", ifc.wbus_out_h);
        end
        tick();
    endtask

    task automatic test_forced_way();
        wr_reg(3, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            ifc.wctrl_h = C_TB_WB;
            #1;
            checks++;
            if (ifc.tb_grp_wr_h !== 4'b0100 || exp_grp() !== 4'b0100) begin
                errors++; $display("FAIL forced_strobe%0d got %h exp 4", i, ifc.tb_grp_wr_h);
            end
            $display("txn forced miss %0d grp=%h", i, ifc.tb_grp_wr_h);
            tick();
        end
        idle_inputs();
        ifc.wctrl_h = C_SCAR_WB; ifc.wbus_h = 4'd5;
        tick();
        idle_inputs();
        ifc.wctrl_h = C_SCR_RD;
        #1;
        checks++;
        if (ifc.wbus_out_h !== 4'b0000 || exp_rd() !== 4'b0000) begin
            errors++; $display("FAIL forced_ptr_held got %h exp 0", ifc.wbus_out_h);
        end
        idle_inputs();
        ifc.phase_1_h = 1'b1; ifc.tb_hit_h = 4'b0011;
        tick();
        idle_inputs();
        ifc.wctrl_h = C_TB_WB;
        #1;
        checks++;
        if (ifc.tb_grp_wr_h !== 4'b0011 || exp_grp() !== 4'b0011) begin
            errors++; $display("FAIL multi_hit got %h exp 3", ifc.tb_grp_wr_h);
        end
        $display("txn hit write grp=%h", ifc.tb_grp_wr_h);
        tick();
    endtask

    task automatic test_sweep();
        int stalls = 0, busy_cycles = 0, done_cnt = 0;
        wr_reg(3, 0);
        ifc.phase_1_h = 1'b1; ifc.tb_hit_h = '0;
        tick();
        wr_reg(4, 1);
        for (int c = 0; c < 30; c++) begin
            idle_inputs();
            if (m_busy != 0 && m_idx == 3 && stalls < 2) begin
                ifc.sweep_stall_h = 1'b1; stalls++;
            end
            if (c == 4) ifc.wctrl_h = C_TB_WB;
            #1;
            checks++;
            if (dut_regs() !== exp_regs() || ifc.tb_grp_wr_h !== exp_grp()
                || ifc.tb_inval_all_h !== m_busy[0]) begin
                errors++;
                $display("FAIL sweep_cycle%0d got regs=%h grp=%h inval=%b exp regs=%h grp=%h inval=%b",
                         c, dut_regs(), ifc.tb_grp_wr_h, ifc.tb_inval_all_h,
                         exp_regs(), exp_grp(), m_busy[0]);
            end
            if (ifc.sweep_busy_h === 1'b1) busy_cycles++;
            if (ifc.sweep_done_h === 1'b1) done_cnt++;
            $display("txn sweep c=%0d busy=%b idx=%0d grp=%h", c, ifc.sweep_busy_h,
                     ifc.tb_index_h, ifc.tb_grp_wr_h);
            tick();
        end
        checks++;
        if (busy_cycles != 10) begin
            errors++; $display("FAIL sweep_busy_cycles got %0d exp 10", busy_cycles);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL sweep_done_pulses got %0d exp 1", done_cnt);
        end
        idle_inputs();
        ifc.wctrl_h = C_SCAR_WB; ifc.wbus_h = 4'd5;
        tick();
        idle_inputs();
        ifc.wctrl_h = C_SCR_RD;
        #1;
        checks++;
        if (ifc.wbus_out_h !== 4'b0000 || exp_rd() !== 4'b0000) begin
            errors++; $display("FAIL sweep_ptr_held got %h exp 0", ifc.wbus_out_h);
        end
        tick();
    endtask

    task automatic test_sweep_reset();
        int done_cnt = 0;
        wr_reg(4, 1);
        for (int c = 0; c < 20 && m_idx != 5; c++) tick();
        checks++;
        if (ifc.tb_index_h !== 3'd5 || ifc.sweep_busy_h !== 1'b1) begin
            errors++; $display("FAIL sweep_reach5 got idx=%0d busy=%b exp idx=5 busy=1",
                               ifc.tb_index_h, ifc.sweep_busy_h);
        end
        rst_l = 1'b0;
        tick();
        #1;
        checks++;
        if ({ifc.sweep_busy_h, ifc.tb_index_h, ifc.sweep_done_h} !== 5'b0 || exp_regs() !== 11'h0) begin
            errors++; $display("FAIL sweep_reset got busy=%b idx=%0d done=%b exp 0 0 0",
                               ifc.sweep_busy_h, ifc.tb_index_h, ifc.sweep_done_h);
        end
        $display("txn sweep reset busy=%b idx=%0d", ifc.sweep_busy_h, ifc.tb_index_h);
        rst_l = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ifc.sweep_done_h !== 1'b0) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++; $display("FAIL sweep_reset_nodone got %0d pulses exp 0", done_cnt);
        end
    endtask

    task automatic test_wvor();
        idle_inputs();
        ifc.wctrl_h = C_SCAR_WB; ifc.wbus_h = 4'd2;
        tick();
        ifc.wctrl_h = C_SCR_WB; ifc.wbus_h = 4'd0; ifc.write_vect_occ_l = 1'b0;
        tick();
        idle_inputs();
        checks++;
        if (ifc.wr_vect_h !== 1'b1 || m_wvor != 1) begin
            errors++; $display("FAIL wvor_set_priority got %b exp 1", ifc.wr_vect_h);
        end
        ifc.bus_grant_dec_h = 1'b1; ifc.phase_1_h = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (ifc.wr_vect_h !== 1'b0 || m_wvor != 0) begin
            errors++; $display("FAIL wvor_clear got %b exp 0", ifc.wr_vect_h);
        end
        $display("txn wvor set/clear wvor=%b", ifc.wr_vect_h);
    endtask

    task automatic test_random();
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 6))
                0: ifc.wctrl_h = C_IDLE;
                1: ifc.wctrl_h = C_SCAR_WB;
                2: ifc.wctrl_h = C_SCR_WB;
                3: ifc.wctrl_h = C_SCR_RD;
                4: ifc.wctrl_h = C_TB_WB;
                5: ifc.wctrl_h = C_CLRTB;
                default: ifc.wctrl_h = 6'($urandom);
            endcase
            ifc.wbus_h           = 4'($urandom);
            ifc.d_clk_en_h       = ($urandom_range(0, 3) != 0);
            ifc.phase_1_h        = ($urandom_range(0, 2) == 0);
            ifc.tb_hit_h         = ($urandom_range(0, 1) == 0) ? '0 : WAYS'($urandom);
            ifc.inval_check_h    = ($urandom_range(0, 3) == 0);
            ifc.write_vect_occ_l = ($urandom_range(0, 7) != 0);
            ifc.bus_grant_dec_h  = ($urandom_range(0, 3) == 0);
            ifc.sweep_stall_h    = ($urandom_range(0, 3) == 0);
            rst_l                = ($urandom_range(0, 60) != 0);
            #1;
            checks++;
            if (ifc.tb_grp_wr_h !== exp_grp() || ifc.wbus_out_h !== exp_rd()
                || ifc.tb_inval_all_h !== m_busy[0]) begin
                errors++;
                $display("FAIL rand_comb%0d got grp=%h rd=%h inval=%b exp grp=%h rd=%h inval=%b",
                         t, ifc.tb_grp_wr_h, ifc.wbus_out_h, ifc.tb_inval_all_h,
                         exp_grp(), exp_rd(), m_busy[0]);
            end
            tick();
            checks++;
            if (dut_regs() !== exp_regs()) begin
                errors++; $display("FAIL rand_regs%0d got %h exp %h", t, dut_regs(), exp_regs());
            end
            $display("txn rand %0d wctrl=%h wbus=%h regs=%h", t, ifc.wctrl_h, ifc.wbus_h, dut_regs());
        end
        rst_l = 1'b1;
        idle_inputs();
    endtask

    initial begin
        m_scar = 0; m_mme = 0; m_wvor = 0; m_tbctl = 0; m_ptr = 0;
        m_hit = 0; m_busy = 0; m_idx = 0; m_done = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_mme();
        test_round_robin();
        test_forced_way();
        test_sweep();
        test_sweep_reset();
        test_wvor();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
